// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA stream widths, screen constants and capture FSM state type.
// Imported by the stream interface, the capture block and its bench.
package vga_pkg;

  localparam int VGA_CW    = 11;
  localparam int RGB_W     = 12;
  localparam int H_VISIBLE = 1024;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE,
    DONE
  } capture_state_t;

endpackage

// File: rtl/vga_if.sv
// vga_if: VGA raster stream bundle (timing counters, syncs, blanks, pixel).
// Producers use the out modport, passive taps use the in modport.
interface vga_if;
  import vga_pkg::*;

  logic [VGA_CW-1:0] hcount;
  logic [VGA_CW-1:0] vcount;
  logic              hsync;
  logic              vsync;
  logic              hblnk;
  logic              vblnk;
  logic [RGB_W-1:0]  rgb;

  modport in (
    input hcount, vcount, hsync, vsync,
    input hblnk, vblnk, rgb
  );

  modport out (
    output hcount, vcount, hsync, vsync,
    output hblnk, vblnk, rgb
  );

endinterface

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port buffer, one synchronous write port and
// one registered read port; a colliding read returns the old word.
module capture_ram #(
  parameter int AW = 12,
  parameter int DW = 12
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  // Storage is never cleared, so old contents survive start and reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read samples the array before this edge's write lands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/capture_image.sv
// capture_image: grabs a window of a tapped VGA stream into a {row,col} buffer.
// Optional CAPTURE_CHECKSUM_EN adds a 16-bit wrapping sum of written pixels.
module capture_image
  import vga_pkg::*;
#(
  parameter int  RECT_WIDTH  = 64,
  parameter int  RECT_HEIGHT = 64,
  localparam int AW = $clog2(RECT_WIDTH) + $clog2(RECT_HEIGHT)
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_if.in                in,
  input  logic             start,
  input  logic [11:0]      rect_x_pos,
  input  logic [11:0]      rect_y_pos,
  input  logic [AW-1:0]    rd_addr,
  output logic [RGB_W-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             partial
`ifdef CAPTURE_CHECKSUM_EN
  ,
  output logic [15:0]      checksum
`endif
);

  localparam int LW = $clog2(RECT_WIDTH);
  localparam int LH = $clog2(RECT_HEIGHT);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(RECT_WIDTH * RECT_HEIGHT);
  localparam logic [12:0]   W13  = 13'(RECT_WIDTH);
  localparam logic [12:0]   H13  = 13'(RECT_HEIGHT);

  capture_state_t r_state;
  logic [11:0]    r_x;
  logic [11:0]    r_y;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_done;
  logic           r_partial;
  logic           r_vblnk_d;
  logic           r_we;
  logic [AW-1:0]  r_waddr;
  logic [RGB_W-1:0] r_wdata;
`ifdef CAPTURE_CHECKSUM_EN
  logic [15:0]    r_csum;
`endif

  logic [12:0]   w_hx;
  logic [12:0]   w_vy;
  logic [12:0]   w_x;
  logic [12:0]   w_y;
  logic          w_in_x;
  logic          w_in_y;
  logic          w_vis;
  logic          w_full;
  logic          w_hit;
  logic          w_vrise;
  logic [LW-1:0] w_col;
  logic [LH-1:0] w_row;

  // 13-bit compares keep x+W from wrapping near the 12-bit limit.
  assign w_hx    = 13'(in.hcount);
  assign w_vy    = 13'(in.vcount);
  assign w_x     = 13'(r_x);
  assign w_y     = 13'(r_y);
  assign w_in_x  = (w_hx >= w_x) && (w_hx < w_x + W13);
  assign w_in_y  = (w_vy >= w_y) && (w_vy < w_y + H13);
  assign w_vis   = ~in.hblnk & ~in.vblnk;
  assign w_full  = (r_cnt == FULL);
  assign w_vrise = in.vblnk & ~r_vblnk_d;
  assign w_hit   = (r_state == CAPTURE) && w_vis &&
                   w_in_x && w_in_y && !w_full;
  assign w_col   = in.hcount[LW-1:0] - r_x[LW-1:0];
  assign w_row   = in.vcount[LH-1:0] - r_y[LH-1:0];

  // Write stage: a hit pixel is registered here and lands one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_vblnk_d <= 1'b0;
    end else begin
      r_we      <= w_hit;
      r_waddr   <= {w_row, w_col};
      r_wdata   <= in.rgb;
      r_vblnk_d <= in.vblnk;
    end
  end

  // Control FSM with write counter, checksum and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_partial <= 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_hit) begin
        r_cnt  <= r_cnt + 1'b1;
`ifdef CAPTURE_CHECKSUM_EN
        r_csum <= r_csum + 16'(in.rgb);
`endif
      end
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_x       <= rect_x_pos;
            r_y       <= rect_y_pos;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_partial <= 1'b0;
`ifdef CAPTURE_CHECKSUM_EN
            r_csum    <= '0;
`endif
            r_state   <= ARM;
          end
        end
        ARM: begin
          if (in.vblnk) begin
            r_state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (w_full) begin
            r_partial <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end else if (w_vrise) begin
            r_partial <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign partial = r_partial;
`ifdef CAPTURE_CHECKSUM_EN
  assign checksum = r_csum;
`endif

  capture_ram #(
    .AW (AW),
    .DW (RGB_W)
  ) u_ram (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_we    (r_we),
    .i_waddr (r_waddr),
    .i_wdata (r_wdata),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

endmodule

// File: doc/capture_image.md
# capture_image

Captures a RECT_WIDTH × RECT_HEIGHT window of pixels from a VGA stream into an internal buffer. It is the writer-side counterpart of the image-overlay path: pixels are stored at address {row, col}, the same packing the image ROM uses, so a captured buffer can be read back or drawn like a ROM image. The block taps a `vga_if` stream without altering it; a CPU or test logic arms it with a start pulse and reads the buffer through a synchronous read port.

## Interface
- RECT_WIDTH, 64, window width in pixels; must be a power of two.
- RECT_HEIGHT, 64, window height in pixels; must be a power of two.
- AW, $clog2(RECT_WIDTH)+$clog2(RECT_HEIGHT), buffer address width; derived, never overridden.

- clk  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in  vga_if.in  —  monitored stream: hcount, vcount, hsync, vsync, hblnk, vblnk, rgb[11:0].
- start  in  1  one-cycle arm pulse; ignored while busy.
- rect_x_pos  in  12  window left column; sampled on accepted start.
- rect_y_pos  in  12  window top row; sampled on accepted start.
- rd_addr  in  AW  read address {row, col}.
- rd_data  out  12  buffer word at rd_addr, one cycle later.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- partial  out  1  valid with done; 1 if fewer than W×H pixels were written.
- checksum  out  16  present only with CAPTURE_CHECKSUM_EN.

## Operation
- FSM states: IDLE, ARM, CAPTURE, DONE.
- IDLE: start=1 latches the window position, clears the write counter, sets busy, and moves to ARM.
- ARM: waits for in.vblnk=1, then moves to CAPTURE. This guarantees capture begins at the top of a fresh frame.
- CAPTURE: a pixel is written when all of the following hold:
  - hblnk=0 and vblnk=0;
  - x ≤ hcount < x+RECT_WIDTH;
  - y ≤ vcount < y+RECT_HEIGHT.
- Write address is {(vcount−y)[log2H−1:0], (hcount−x)[log2W−1:0]}.
- Window compares use 13-bit sums, so x+W never wraps; a window extending past the visible area captures only its visible part.
- The write counter (AW+1 bits) increments per write.
- CAPTURE exits to DONE when:
  - the counter reaches W×H (partial=0), or
  - a rising edge of vblnk arrives first (partial=1).
- If both conditions occur in the same cycle, partial=0.
- DONE lasts one cycle: asserts done, clears busy, and returns to IDLE.
- start arriving in DONE is ignored.
- The buffer is not cleared by start or reset; unwritten locations keep old contents.
- Read port: rd_data is registered. A read of an address written in the same cycle returns the old data.

## Timing
- Reset values:
  - state IDLE;
  - busy=0, done=0, partial=0;
  - checksum=0;
  - rd_data=0;
  - latched x/y=0, counter=0.
- Reset mid-capture aborts immediately: no done pulse, buffer contents undefined at aborted locations.
- Write latency: the pixel present at edge N is registered into the write stage at N and written to the buffer at edge N+1.
- done is high in the cycle after the final write edge; all data is readable with rd_addr applied in that cycle.
- start → busy: busy=1 one edge after the start pulse.
- Capture of a full 64×64 window spans at most one frame after ARM exits.

## Configuration
- CAPTURE_CHECKSUM_EN defined:
  - checksum accumulates the 16-bit wrapping sum of the zero-extended rgb of every written pixel;
  - it is cleared on accepted start and is stable from done until the next start.
- Not defined: the checksum port and accumulator are absent.

## Structure
- vga_pkg holds:
  - `capture_state_t` enum (IDLE, ARM, CAPTURE, DONE);
  - screen constants used for bench checks.
- Sub-module `capture_ram`: simple dual-port RAM, depth 2^AW × 12, one synchronous write port and one registered read port, read-old-on-collision.
- Window compare, FSM, counter and checksum live in capture_image.

## Test plan
- Full window: x=100, y=50, in.rgb = {hcount[5:0], vcount[5:0]}; start → done after one frame, partial=0, rd_addr 0x041 → rgb {(100+1)[5:0], (50+1)[5:0]}.
- Off-screen window: x=1000 with 1024 visible columns → done at the next vblnk rise, partial=1; buffer columns 0–23 updated, columns 24–63 unchanged.
- start while busy: second pulse mid-capture → ignored; window stays at the first x/y; exactly one done.
- Reset mid-CAPTURE: rst_n low for 2 cycles → busy=0 and done=0 immediately; a fresh start captures normally.
- Read/write collision: rd_addr equals the address being written → rd_data returns the old value, then the new value one cycle later.
- CAPTURE_CHECKSUM_EN: constant rgb 0x00F over a 64×64 window → checksum 0xF000 at done.
